// File: rtl/pe_row_mac.sv
// N-tap row MAC processing element: pixel x weight products, bias add, rounded
// shift, optional saturation and ReLU, behind a 3-stage ready/valid pipeline.
module pe_row_mac #(
  parameter int TAPS   = 3,
  parameter int PW     = 8,
  parameter int WW     = 8,
  parameter int BW     = 16,
  parameter int SHIFT  = 6,
  parameter int OW     = 11,
  parameter int SAT_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_valid,
  input  logic [WW-1:0]        w_data,
  input  logic [BW-1:0]        bias,
  input  logic                 relu_en,
  input  logic [TAPS*PW-1:0]   p,
  input  logic                 p_valid,
  output logic                 p_ready,
  output logic [OW-1:0]        o,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic                 o_sat
);

  localparam int PPW = WW + PW + 1;
  localparam int AW  = PPW + $clog2(TAPS) + 1;
  localparam int RW  = AW + 1;

  function automatic logic signed [RW-1:0] rnd_const();
    if (SHIFT > 0) begin
      return RW'(1'b1) << (SHIFT - 1);
    end else begin
      return '0;
    end
  endfunction

  localparam logic signed [RW-1:0] RND_C    = rnd_const();
  localparam logic signed [OW-1:0] O_MAX_OW = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] O_MIN_OW = {1'b1, {(OW-1){1'b0}}};
  localparam logic signed [RW-1:0] O_MAX    = RW'(O_MAX_OW);
  localparam logic signed [RW-1:0] O_MIN    = RW'(O_MIN_OW);

  logic signed [WW-1:0]  w_r    [TAPS];
  logic signed [PPW-1:0] prod_r [TAPS];
  logic signed [BW-1:0]  bias1_r;
  logic                  relu1_r;
  logic                  v1_r;
  logic signed [AW-1:0]  sum_r;
  logic                  relu2_r;
  logic                  v2_r;

  logic                  en_s;
  logic signed [AW-1:0]  sum_s;
  logic signed [RW-1:0]  rnd_s;
  logic signed [RW-1:0]  r_s;
  logic [OW-1:0]         clip_s;
  logic                  sat_s;
  logic [OW-1:0]         res_s;

  // The whole pipeline moves as one; the output side alone decides.
  assign en_s    = !o_valid || o_ready;
  assign p_ready = en_s;

  // Serial weight shift register, independent of the pixel handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) w_r[i] <= '0;
    end else if (w_valid) begin
      w_r[0] <= $signed(w_data);
      for (int i = 1; i < TAPS; i++) w_r[i] <= w_r[i-1];
    end
  end

  // Adder tree plus sign-extended bias; AW is wide enough that it never wraps.
  always_comb begin
    sum_s = AW'(bias1_r);
    for (int i = 0; i < TAPS; i++) sum_s = sum_s + AW'(prod_r[i]);
  end

  // Round half up, shift, then clamp or wrap, then ReLU (o_sat stays pre-ReLU).
  always_comb begin
    rnd_s = RW'(sum_r) + RND_C;
    r_s   = rnd_s >>> SHIFT;
    if (SAT_EN != 0) begin
      if (r_s > O_MAX) begin
        clip_s = O_MAX_OW;
        sat_s  = 1'b1;
      end else if (r_s < O_MIN) begin
        clip_s = O_MIN_OW;
        sat_s  = 1'b1;
      end else begin
        clip_s = r_s[OW-1:0];
        sat_s  = 1'b0;
      end
    end else begin
      clip_s = r_s[OW-1:0];
      sat_s  = 1'b0;
    end
    if (relu2_r && clip_s[OW-1]) begin
      res_s = '0;
    end else begin
      res_s = clip_s;
    end
  end

  // Three pipeline stages; bubbles travel along with the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) prod_r[i] <= '0;
      bias1_r <= '0;
      relu1_r <= 1'b0;
      v1_r    <= 1'b0;
      sum_r   <= '0;
      relu2_r <= 1'b0;
      v2_r    <= 1'b0;
      o       <= '0;
      o_sat   <= 1'b0;
      o_valid <= 1'b0;
    end else if (en_s) begin
      v1_r <= p_valid;
      if (p_valid) begin
        for (int i = 0; i < TAPS; i++) begin
          prod_r[i] <= PPW'(w_r[i]) * PPW'($signed({1'b0, p[i*PW +: PW]}));
        end
        bias1_r <= $signed(bias);
        relu1_r <= relu_en;
      end
      v2_r    <= v1_r;
      sum_r   <= sum_s;
      relu2_r <= relu1_r;
      o_valid <= v2_r;
      o       <= res_s;
      o_sat   <= sat_s;
    end
  end

endmodule

// File: tb/tb_pe_row_mac.sv
// Self-checking bench for pe_row_mac: directed table, stall and reset
// sequences, and randomized traffic against an arithmetic reference model.
module tb_pe_row_mac;

  localparam int TAPS  = 3;
  localparam int PW    = 8;
  localparam int WW    = 8;
  localparam int BW    = 16;
  localparam int SHIFT = 6;
  localparam int OW    = 11;
  localparam int PBITS = TAPS * PW;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, w_valid, relu_en, p_valid, o_ready;
  logic [WW-1:0]    w_data;
  logic [BW-1:0]    bias;
  logic [PBITS-1:0] p;
  logic             p_ready, p_ready0, o_valid, o_valid0, o_sat, o_sat0;
  logic [OW-1:0]    o, o0;

  pe_row_mac #(.TAPS(TAPS), .PW(PW), .WW(WW), .BW(BW), .SHIFT(SHIFT), .OW(OW), .SAT_EN(1)) dut (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_data(w_data), .bias(bias), .relu_en(relu_en),
    .p(p), .p_valid(p_valid), .p_ready(p_ready), .o(o), .o_valid(o_valid), .o_ready(o_ready),
    .o_sat(o_sat));

  pe_row_mac #(.TAPS(TAPS), .PW(PW), .WW(WW), .BW(BW), .SHIFT(SHIFT), .OW(OW), .SAT_EN(0)) dut0 (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_data(w_data), .bias(bias), .relu_en(relu_en),
    .p(p), .p_valid(p_valid), .p_ready(p_ready0), .o(o0), .o_valid(o_valid0), .o_ready(o_ready),
    .o_sat(o_sat0));

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    longint o1; bit s1; longint o0; bit s0;
  } exp_t;

  typedef struct {
    longint w2, w1, w0;
    longint p2, p1, p0;
    longint b;
    bit     relu;
    longint e1; bit s1;
    longint e0; bit s0;
  } vec_t;

  longint        mw[TAPS];
  exp_t          sb[$];
  bit            held;
  logic [OW-1:0] held_o;
  logic          held_s;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sgn(input logic [OW-1:0] v);
    return longint'($signed(v));
  endfunction

  // Reference: plain integer arithmetic on the current model weights.
  function automatic exp_t model(input logic [PBITS-1:0] px, input longint bv, input bit relu);
    longint s, r, hi, lo, wrap;
    exp_t e;
    s = bv;
    for (int i = 0; i < TAPS; i++) s += mw[i] * longint'(px[i*PW +: PW]);
    r    = (s + 64'sd32) >>> SHIFT;
    hi   = (64'sd1 <<< (OW - 1)) - 64'sd1;
    lo   = -(64'sd1 <<< (OW - 1));
    e.o1 = (r > hi) ? hi : ((r < lo) ? lo : r);
    e.s1 = (r > hi) || (r < lo);
    wrap = r & ((64'sd1 <<< OW) - 64'sd1);
    if (wrap > hi) wrap -= (64'sd1 <<< OW);
    e.o0 = wrap;
    e.s0 = 1'b0;
    if (relu && e.o1 < 0) e.o1 = 0;
    if (relu && e.o0 < 0) e.o0 = 0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic loadw(input longint a2, input longint a1, input longint a0);
    w_valid = 1'b1;
    w_data = 8'(a2); step();
    w_data = 8'(a1); step();
    w_data = 8'(a0); step();
    w_valid = 1'b0;
  endtask

  // Monitor: tracks accepts/weight loads into the scoreboard, checks every retired beat.
  initial begin
    exp_t e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        sb.delete();
        for (int i = 0; i < TAPS; i++) mw[i] = 0;
        held = 1'b0;
      end else begin
        chk("p_ready_rule", p_ready, (!o_valid || o_ready));
        chk("o_valid_nosat", o_valid0, o_valid);
        if (held) begin
          chk("hold_valid", o_valid, 1);
          chk("hold_o", sgn(o), sgn(held_o));
          chk("hold_sat", o_sat, held_s);
        end
        if (p_valid && p_ready) sb.push_back(model(p, longint'($signed(bias)), relu_en));
        if (w_valid) begin
          for (int i = TAPS - 1; i > 0; i--) mw[i] = mw[i-1];
          mw[0] = longint'($signed(w_data));
        end
        if (sb.size() == 0) begin
          chk("no_stale_out", o_valid && o_ready, 0);
        end else if (o_valid && o_ready) begin
          e = sb.pop_front();
          chk("sb_o", sgn(o), e.o1);
          chk("sb_sat", o_sat, e.s1);
          chk("sb_o_nosat", sgn(o0), e.o0);
          chk("sb_sat_nosat", o_sat0, e.s0);
        end
        held   = o_valid && !o_ready;
        held_o = o;
        held_s = o_sat;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    bit   acc;
    int   idx;

    tbl[0] = '{3, 2, 1, 64, 64, 64, 0, 1'b0, 6, 1'b0, 6, 1'b0};
    tbl[1] = '{127, 127, 127, 255, 255, 255, 0, 1'b0, 1023, 1'b1, -530, 1'b0};
    tbl[2] = '{-128, -128, -128, 255, 255, 255, 0, 1'b0, -1024, 1'b1, 518, 1'b0};
    tbl[3] = '{-128, -128, -128, 255, 255, 255, 0, 1'b1, 0, 1'b1, 518, 1'b0};
    tbl[4] = '{0, 0, 1, 0, 0, 32, 0, 1'b0, 1, 1'b0, 1, 1'b0};
    tbl[5] = '{0, 0, 1, 0, 0, 31, 0, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[6] = '{0, 0, 1, 0, 0, 0, -33, 1'b0, -1, 1'b0, -1, 1'b0};
    tbl[7] = '{0, 0, 1, 0, 0, 0, -33, 1'b1, 0, 1'b0, 0, 1'b0};

    rst = 1'b1; w_valid = 1'b0; w_data = '0; bias = '0; relu_en = 1'b0;
    p = '0; p_valid = 1'b0; o_ready = 1'b1; acc = 1'b0;
    step(); step();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o", sgn(o), 0);
    chk("rst_o_sat", o_sat, 0);
    chk("rst_p_ready", p_ready, 1);
    rst = 1'b0;
    step();
    chk("post_rst_o_valid", o_valid, 0);
    chk("post_rst_p_ready", p_ready, 1);

    // Directed table: exact 3-cycle latency and known results.
    foreach (tbl[k]) begin
      loadw(tbl[k].w2, tbl[k].w1, tbl[k].w0);
      p = {8'(tbl[k].p2), 8'(tbl[k].p1), 8'(tbl[k].p0)};
      bias = 16'(tbl[k].b);
      relu_en = tbl[k].relu;
      p_valid = 1'b1;
      step();
      p_valid = 1'b0;
      chk("lat_c1_valid", o_valid, 0);
      step();
      chk("lat_c2_valid", o_valid, 0);
      step();
      chk("lat_c3_valid", o_valid, 1);
      chk("tbl_o", sgn(o), tbl[k].e1);
      chk("tbl_sat", o_sat, tbl[k].s1);
      chk("tbl_o_nosat", sgn(o0), tbl[k].e0);
      chk("tbl_sat_nosat", o_sat0, tbl[k].s0);
      step();
    end

    // Eight back-to-back beats with a downstream stall and a weight load mid-stall.
    loadw(5, -7, 11);
    relu_en = 1'b0;
    idx = 0;
    p_valid = 1'b1; p = PBITS'($urandom); bias = 16'($urandom_range(0, 2000));
    for (int cyc = 0; cyc < 60 && idx < 8; cyc++) begin
      o_ready = !(cyc >= 4 && cyc <= 7);
      w_valid = (cyc == 5 || cyc == 6);
      w_data  = 8'($urandom);
      @(negedge clk);
      if (cyc == 5) chk("stall_p_ready", p_ready, 0);
      acc = p_valid && p_ready;
      step();
      if (acc) begin
        idx++;
        p = PBITS'($urandom);
        bias = 16'($urandom_range(0, 2000));
      end
    end
    chk("stall_beats_sent", idx, 8);
    p_valid = 1'b0; w_valid = 1'b0; o_ready = 1'b1;
    repeat (8) step();
    chk("stall_drained", sb.size(), 0);

    // Reset with three beats in flight; weights must come back cleared.
    loadw(9, -3, 7);
    p_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p = PBITS'($urandom); bias = 16'($urandom);
      step();
    end
    p_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_o", sgn(o), 0);
    chk("midrst_p_ready", p_ready, 1);
    repeat (5) step();
    p = PBITS'($urandom); bias = 16'd64; relu_en = 1'b0; p_valid = 1'b1;
    step();
    p_valid = 1'b0;
    step(); step();
    chk("norld_valid", o_valid, 1);
    chk("norld_o", sgn(o), 1);
    step();

    // Randomized traffic; the source holds its beat until accepted.
    acc = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      o_ready = ($urandom_range(0, 3) != 0);
      w_valid = ($urandom_range(0, 15) == 0);
      w_data  = 8'($urandom);
      if (!p_valid || acc) begin
        p_valid = ($urandom_range(0, 2) != 0);
        p       = PBITS'($urandom);
        bias    = 16'($urandom);
        relu_en = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      acc = p_valid && p_ready;
      step();
    end
    p_valid = 1'b0; w_valid = 1'b0; o_ready = 1'b1;
    repeat (20) step();
    chk("final_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
